// File: rtl/noc_params.sv
// Shared NoC types: flit layout, flit labels, output ports and the
// per-VC pipeline stages used by the router input buffers.
package noc_params;

    localparam int VC_NUM    = 4;
    localparam int VC_SIZE   = $clog2(VC_NUM);
    localparam int DATA_SIZE = 16;

    typedef enum logic [1:0] {
        HEAD     = 2'd0,
        BODY     = 2'd1,
        TAIL     = 2'd2,
        HEADTAIL = 2'd3
    } flit_label_t;

    typedef enum logic [2:0] {
        LOCAL = 3'd0,
        NORTH = 3'd1,
        SOUTH = 3'd2,
        WEST  = 3'd3,
        EAST  = 3'd4
    } port_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        VA   = 2'd1,
        SA   = 2'd2
    } ss_t;

    typedef struct packed {
        flit_label_t            flit_label;
        logic [VC_SIZE-1:0]     vc_id;
        logic [DATA_SIZE-1:0]   data;
    } flit_t;

    // True for the labels that open a packet and therefore carry a route.
    function automatic logic is_head_label(input flit_label_t label);
        return (label == HEAD) || (label == HEADTAIL);
    endfunction

    // True for the labels that close a packet.
    function automatic logic is_tail_label(input flit_label_t label);
        return (label == TAIL) || (label == HEADTAIL);
    endfunction

endpackage

// File: rtl/input_buffer_if.sv
// Bundle between an input buffer and its router: upstream flit write,
// allocator grants and the buffer's requests and status back out.
interface input_buffer_if;
    import noc_params::*;

    flit_t              data_i;
    logic               write_i;
    logic               read_i;
    port_t              out_port_i;
    logic               vc_valid_i;
    logic [VC_SIZE-1:0] vc_new_i;

    flit_t              data_o;
    port_t              out_port_o;
    logic [VC_SIZE-1:0] downstream_vc_o;
    logic               vc_request_o;
    logic               switch_request_o;
    logic               vc_allocatable_o;
    logic               on_off_o;
    logic               error_o;
    logic               is_full_o;
    logic               is_empty_o;

    modport master (
        output data_i, write_i, read_i, out_port_i, vc_valid_i, vc_new_i,
        input  data_o, out_port_o, downstream_vc_o, vc_request_o,
               switch_request_o, vc_allocatable_o, on_off_o, error_o,
               is_full_o, is_empty_o
    );

    modport slave (
        input  data_i, write_i, read_i, out_port_i, vc_valid_i, vc_new_i,
        output data_o, out_port_o, downstream_vc_o, vc_request_o,
               switch_request_o, vc_allocatable_o, on_off_o, error_o,
               is_full_o, is_empty_o
    );

endinterface

// File: rtl/circular_buffer.sv
// Flit storage ring with show-ahead read. The owner decides when a push
// or pop is legal; this block only moves pointers and stores flits.
module circular_buffer
    import noc_params::*;
#(
    parameter int BUFFER_SIZE = 8
) (
    input  logic  clk,
    input  logic  rst,
    input  flit_t data_i,
    input  logic  push_i,
    input  logic  pop_i,
    output flit_t data_o
);

    localparam int PTR_W = (BUFFER_SIZE > 1) ? $clog2(BUFFER_SIZE) : 1;
    localparam logic [PTR_W-1:0] LAST_SLOT = PTR_W'(BUFFER_SIZE - 1);

    flit_t            mem_q [BUFFER_SIZE];
    flit_t            mem_d [BUFFER_SIZE];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;

    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == LAST_SLOT) ? '0 : ptr + 1'b1;
    endfunction

    // Next storage contents and pointer positions for a push and/or pop.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_i) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d        = wrap_inc(wr_ptr_q);
        end
        if (pop_i) begin
            rd_ptr_d = wrap_inc(rd_ptr_q);
        end
    end

    // Storage needs no reset: emptiness is tracked by the owner's counter.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Pointer registers; reset discards every buffered flit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    assign data_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/input_buffer.sv
// Router input buffer for one VC: stores the flits of a single packet,
// walks it through VC allocation and switch allocation, and rejects
// flits that break the packet protocol.
module input_buffer
    import noc_params::*;
#(
    parameter int BUFFER_SIZE    = 8,
    parameter int ON_OFF_LATENCY = 2
) (
    input logic           clk,
    input logic           rst,
    input_buffer_if.slave ib
);

    localparam int CNT_W = $clog2(BUFFER_SIZE + 1);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(BUFFER_SIZE);

    ss_t                state_q, state_d;
    port_t              out_port_q, out_port_d;
    logic [VC_SIZE-1:0] downstream_vc_q, downstream_vc_d;
    logic [CNT_W-1:0]   occupancy_q, occupancy_d;
    logic               on_off_q, on_off_d;
    logic               error_q, error_d;

    logic  push, pop;
    logic  is_empty, is_full;
    logic  pop_ok, tail_popped, has_room, head_written;
    flit_t front_flit, fifo_front;

    circular_buffer #(
        .BUFFER_SIZE (BUFFER_SIZE)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .data_i (ib.data_i),
        .push_i (push),
        .pop_i  (pop),
        .data_o (fifo_front)
    );

    assign is_empty     = (occupancy_q == '0);
    assign is_full      = (occupancy_q == FULL_COUNT);
    assign pop_ok       = ib.read_i && (state_q == SA) && !is_empty;
    assign tail_popped  = pop_ok && is_tail_label(fifo_front.flit_label);
    assign has_room     = !is_full || pop_ok;
    assign head_written = is_head_label(ib.data_i.flit_label);

    // Packet FSM: decides which writes are accepted, when to pop, and
    // latches the route and granted VC as the packet advances.
    always_comb begin
        state_d         = state_q;
        out_port_d      = out_port_q;
        downstream_vc_d = downstream_vc_q;
        push            = 1'b0;
        pop             = pop_ok;
        error_d         = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (ib.write_i) begin
                    if (head_written && has_room) begin
                        push       = 1'b1;
                        out_port_d = ib.out_port_i;
                        state_d    = VA;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            VA: begin
                if (ib.write_i) begin
                    if (!head_written && has_room) push = 1'b1;
                    else                           error_d = 1'b1;
                end
                if (ib.vc_valid_i) begin
                    downstream_vc_d = ib.vc_new_i;
                    state_d         = SA;
                end
            end
            SA: begin
                if (tail_popped) state_d = IDLE;
                if (ib.write_i) begin
                    if (head_written) begin
                        if (tail_popped && has_room) begin
                            push       = 1'b1;
                            out_port_d = ib.out_port_i;
                            state_d    = VA;
                        end else begin
                            error_d = 1'b1;
                        end
                    end else if (has_room) begin
                        push = 1'b1;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Occupancy follows the accepted push/pop; flow-control credit
    // reflects the occupancy that will hold after this edge.
    always_comb begin
        occupancy_d = occupancy_q;
        if (push && !pop)      occupancy_d = occupancy_q + 1'b1;
        else if (pop && !push) occupancy_d = occupancy_q - 1'b1;
        on_off_d = (BUFFER_SIZE - int'(occupancy_d)) > ON_OFF_LATENCY;
    end

    // Control registers; reset abandons any packet in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            out_port_q      <= LOCAL;
            downstream_vc_q <= '0;
            occupancy_q     <= '0;
            on_off_q        <= 1'b1;
            error_q         <= 1'b0;
        end else begin
            state_q         <= state_d;
            out_port_q      <= out_port_d;
            downstream_vc_q <= downstream_vc_d;
            occupancy_q     <= occupancy_d;
            on_off_q        <= on_off_d;
            error_q         <= error_d;
        end
    end

    // Head flits leave carrying the downstream VC instead of the upstream one.
    always_comb begin
        front_flit = fifo_front;
        if (is_head_label(fifo_front.flit_label)) front_flit.vc_id = downstream_vc_q;
    end

    assign ib.data_o           = front_flit;
    assign ib.out_port_o       = out_port_q;
    assign ib.downstream_vc_o  = downstream_vc_q;
    assign ib.vc_request_o     = (state_q == VA);
    assign ib.switch_request_o = (state_q == SA) && !is_empty;
    assign ib.vc_allocatable_o = (state_q == IDLE) && is_empty;
    assign ib.on_off_o         = on_off_q;
    assign ib.error_o          = error_q;
    assign ib.is_full_o        = is_full;
    assign ib.is_empty_o       = is_empty;

endmodule

// File: tb/tb_input_buffer.sv
// Directed bench for input_buffer: single-flit packet, fill to full,
// full read/write streaming, back-to-back packets, protocol errors and
// mid-packet reset.
module tb_input_buffer;
    import noc_params::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    input_buffer_if bus ();

    input_buffer #(
        .BUFFER_SIZE    (8),
        .ON_OFF_LATENCY (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .ib  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic flit_t mkFlit(input flit_label_t label, input logic [DATA_SIZE-1:0] d);
        flit_t f;
        f.flit_label = label;
        f.vc_id      = '0;
        f.data       = d;
        return f;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs, let the edge happen, then sample 1ns later.
    task automatic applyStimulus(input logic wr, input flit_t f, input logic rd,
                                 input port_t port, input logic vv,
                                 input logic [VC_SIZE-1:0] vn);
        bus.write_i    = wr;
        bus.data_i     = f;
        bus.read_i     = rd;
        bus.out_port_i = port;
        bus.vc_valid_i = vv;
        bus.vc_new_i   = vn;
        @(posedge clk);
        #1;
        bus.write_i    = 1'b0;
        bus.read_i     = 1'b0;
        bus.vc_valid_i = 1'b0;
        bus.vc_new_i   = '0;
    endtask

    task automatic pulseReset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        #1;
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_empty"},    32'(bus.is_empty_o),       32'd1);
        checkOutput({tag, "_full"},     32'(bus.is_full_o),        32'd0);
        checkOutput({tag, "_on_off"},   32'(bus.on_off_o),         32'd1);
        checkOutput({tag, "_alloc"},    32'(bus.vc_allocatable_o), 32'd1);
        checkOutput({tag, "_vc_req"},   32'(bus.vc_request_o),     32'd0);
        checkOutput({tag, "_sw_req"},   32'(bus.switch_request_o), 32'd0);
        checkOutput({tag, "_error"},    32'(bus.error_o),          32'd0);
        checkOutput({tag, "_out_port"}, 32'(bus.out_port_o),       32'd0);
        checkOutput({tag, "_ds_vc"},    32'(bus.downstream_vc_o),  32'd0);
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        rst            = 1'b1;
        bus.write_i    = 1'b0;
        bus.read_i     = 1'b0;
        bus.vc_valid_i = 1'b0;
        bus.vc_new_i   = '0;
        bus.out_port_i = LOCAL;
        bus.data_i     = mkFlit(BODY, '0);
        #12;
        rst = 1'b0;
        #1;
        checkResetState("reset");

        // Single HEADTAIL packet through VA and SA.
        applyStimulus(1'b1, mkFlit(HEADTAIL, 16'h00A1), 1'b0, EAST, 1'b0, '0);
        checkOutput("ht_vc_req",   32'(bus.vc_request_o),     32'd1);
        checkOutput("ht_out_port", 32'(bus.out_port_o),       32'(EAST));
        checkOutput("ht_alloc",    32'(bus.vc_allocatable_o), 32'd0);
        checkOutput("ht_empty",    32'(bus.is_empty_o),       32'd0);
        applyStimulus(1'b0, mkFlit(BODY, '0), 1'b0, LOCAL, 1'b1, 2'd1);
        checkOutput("ht_sw_req",   32'(bus.switch_request_o), 32'd1);
        checkOutput("ht_vc_req_0", 32'(bus.vc_request_o),     32'd0);
        checkOutput("ht_ds_vc",    32'(bus.downstream_vc_o),  32'd1);
        checkOutput("ht_out_vc",   32'(bus.data_o.vc_id),     32'd1);
        checkOutput("ht_out_data", 32'(bus.data_o.data),      32'h00A1);
        applyStimulus(1'b0, mkFlit(BODY, '0), 1'b1, LOCAL, 1'b0, '0);
        checkOutput("ht_idle_alloc", 32'(bus.vc_allocatable_o), 32'd1);
        checkOutput("ht_idle_empty", 32'(bus.is_empty_o),       32'd1);
        checkOutput("ht_idle_sw",    32'(bus.switch_request_o), 32'd0);
        checkOutput("ht_idle_err",   32'(bus.error_o),          32'd0);

        // Fill with HEAD + 6 BODY + TAIL, no reads.
        for (int i = 0; i < 8; i++) begin
            flit_label_t lbl;
            lbl = (i == 0) ? HEAD : ((i == 7) ? TAIL : BODY);
            applyStimulus(1'b1, mkFlit(lbl, 16'(i)), 1'b0, NORTH, 1'b0, '0);
            checkOutput($sformatf("fill_on_off_%0d", i), 32'(bus.on_off_o),  32'((8 - (i + 1)) > 2));
            checkOutput($sformatf("fill_full_%0d", i),   32'(bus.is_full_o), 32'(i == 7));
            checkOutput($sformatf("fill_err_%0d", i),    32'(bus.error_o),   32'd0);
        end
        checkOutput("fill_out_port", 32'(bus.out_port_o), 32'(NORTH));
        applyStimulus(1'b1, mkFlit(BODY, 16'h0099), 1'b0, LOCAL, 1'b0, '0);
        checkOutput("ovf_error",   32'(bus.error_o),      32'd1);
        checkOutput("ovf_full",    32'(bus.is_full_o),    32'd1);
        checkOutput("ovf_front",   32'(bus.data_o.data),  32'd0);
        checkOutput("ovf_vc_req",  32'(bus.vc_request_o), 32'd1);
        applyStimulus(1'b0, mkFlit(BODY, '0), 1'b0, LOCAL, 1'b0, '0);
        checkOutput("ovf_err_end", 32'(bus.error_o),      32'd0);

        // Grant VC, then stream read+write while full.
        applyStimulus(1'b0, mkFlit(BODY, '0), 1'b0, LOCAL, 1'b1, 2'd2);
        checkOutput("sa_sw_req",  32'(bus.switch_request_o), 32'd1);
        checkOutput("sa_head_vc", 32'(bus.data_o.vc_id),      32'd2);
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("rw_front_%0d", i), 32'(bus.data_o.data), 32'(i));
            applyStimulus(1'b1, mkFlit(BODY, 16'(8 + i)), 1'b1, LOCAL, 1'b0, '0);
            checkOutput($sformatf("rw_full_%0d", i),  32'(bus.is_full_o), 32'd1);
            checkOutput($sformatf("rw_err_%0d", i),   32'(bus.error_o),   32'd0);
        end
        checkOutput("rw_front_next", 32'(bus.data_o.data), 32'd3);

        pulseReset();
        checkResetState("reset2");

        // Tail popped while the next HEAD arrives in the same cycle.
        applyStimulus(1'b1, mkFlit(HEAD, 16'h0040), 1'b0, SOUTH, 1'b0, '0);
        applyStimulus(1'b1, mkFlit(TAIL, 16'h0041), 1'b0, LOCAL, 1'b0, '0);
        applyStimulus(1'b0, mkFlit(BODY, '0), 1'b0, LOCAL, 1'b1, 2'd3);
        checkOutput("b2b_head_vc", 32'(bus.data_o.vc_id), 32'd3);
        applyStimulus(1'b0, mkFlit(BODY, '0), 1'b1, LOCAL, 1'b0, '0);
        checkOutput("b2b_tail_front", 32'(bus.data_o.data), 32'h0041);
        applyStimulus(1'b1, mkFlit(HEAD, 16'h0050), 1'b1, WEST, 1'b0, '0);
        checkOutput("b2b_vc_req",   32'(bus.vc_request_o),     32'd1);
        checkOutput("b2b_sw_req",   32'(bus.switch_request_o), 32'd0);
        checkOutput("b2b_out_port", 32'(bus.out_port_o),       32'(WEST));
        checkOutput("b2b_error",    32'(bus.error_o),          32'd0);
        checkOutput("b2b_front",    32'(bus.data_o.data),      32'h0050);
        checkOutput("b2b_empty",    32'(bus.is_empty_o),       32'd0);

        pulseReset();

        // BODY in IDLE is an error; a read while empty is silently ignored.
        applyStimulus(1'b1, mkFlit(BODY, 16'h0077), 1'b0, LOCAL, 1'b0, '0);
        checkOutput("idle_body_err",   32'(bus.error_o),          32'd1);
        checkOutput("idle_body_empty", 32'(bus.is_empty_o),       32'd1);
        checkOutput("idle_body_alloc", 32'(bus.vc_allocatable_o), 32'd1);
        applyStimulus(1'b0, mkFlit(BODY, '0), 1'b1, LOCAL, 1'b0, '0);
        checkOutput("empty_rd_err",    32'(bus.error_o),          32'd0);
        checkOutput("empty_rd_empty",  32'(bus.is_empty_o),       32'd1);

        // Mid-packet asynchronous reset with four flits held in SA.
        applyStimulus(1'b1, mkFlit(HEAD, 16'h0060), 1'b0, EAST, 1'b0, '0);
        applyStimulus(1'b0, mkFlit(BODY, '0), 1'b0, LOCAL, 1'b1, 2'd3);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, mkFlit(BODY, 16'(16'h0061 + i)), 1'b0, LOCAL, 1'b0, '0);
        end
        checkOutput("pre_rst_sw_req", 32'(bus.switch_request_o), 32'd1);
        checkOutput("pre_rst_ds_vc",  32'(bus.downstream_vc_o),  32'd3);
        #2;
        rst = 1'b1;
        #1;
        checkResetState("mid_rst");
        #1;
        rst = 1'b0;
        applyStimulus(1'b0, mkFlit(BODY, '0), 1'b1, LOCAL, 1'b0, '0);
        checkOutput("post_rst_empty", 32'(bus.is_empty_o), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
